instr_sequencer: RTL and testbench

- Multi-cycle control FSM for the mini RISC-V core. Steps each instruction through FETCH, DECODE, EXECUTE, optional MEM and WRITEBACK.
- Issues request/acknowledge handshakes to instruction and data memory, consuming the instruction decoder's control outputs.
- Generates the one-cycle strobes that latch the IR, write the register file and update the PC.
- Counts retired instructions and traps on illegal instructions or memory timeouts.

---
 rtl/instr_sequencer_pkg.sv | 23 ++
 rtl/instr_sequencer_req_timer.sv | 34 +++
 rtl/instr_sequencer.sv | 123 ++++++++++++
 tb/tb_instr_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared state and trap-cause encodings for the instruction sequencer
package instr_sequencer_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_IMEM_TO = 2'b10,
    CAUSE_DMEM_TO = 2'b11
  } cause_e;

endpackage

// File: rtl/instr_sequencer_req_timer.sv
// rtl/instr_sequencer_req_timer.sv - loadable 8-bit wait counter shared by the fetch and data-memory handshakes
module req_timer
  import instr_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_limit,
  input  logic               i_clear,
  input  logic               i_inc,
  output logic               o_expired
);

  logic [TIMER_W-1:0] r_count;
  logic [TIMER_W-1:0] r_limit;

  // Load restarts the count and captures the last wait cycle allowed for this request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_limit <= '0;
    end else if (i_load) begin
      r_count <= '0;
      r_limit <= i_limit;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && !o_expired) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  assign o_expired = (r_count == r_limit);

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/execute/mem/writeback control FSM with retire counter and traps
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_load,
  input  logic             valid_inst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_we,
  output logic [CNT_W-1:0] retired,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state_o
);

  localparam logic [TIMER_W-1:0] LP_LIMIT = TIMER_W'(TIMEOUT - 1);

  state_e           r_state;
  cause_e           r_cause;
  logic             r_dmem_we;
  logic [CNT_W-1:0] r_retired;

  logic w_enter_req;
  logic w_in_req;
  logic w_wait;
  logic w_expired;

  // Asserted in the cycle whose clock edge moves the FSM into FETCH or MEM.
  assign w_enter_req = ((r_state == ST_IDLE || r_state == ST_WRITEBACK) && run) ||
                       (r_state == ST_EXECUTE && (mem_read || mem_write));
  assign w_in_req    = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_wait      = ((r_state == ST_FETCH) && !imem_ack) ||
                       ((r_state == ST_MEM) && !dmem_ack);

  req_timer u_req_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_enter_req),
    .i_limit   (LP_LIMIT),
    .i_clear   (!w_in_req),
    .i_inc     (w_wait),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cause   <= CAUSE_NONE;
      r_dmem_we <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          // An ack on the final allowed wait cycle takes priority over the timeout.
          if (imem_ack) begin
            r_state <= ST_DECODE;
          end else if (w_expired) begin
            r_state <= ST_TRAP;
            r_cause <= CAUSE_IMEM_TO;
          end
        end
        ST_DECODE: begin
          if (!valid_inst) begin
            r_state <= ST_TRAP;
            r_cause <= CAUSE_ILLEGAL;
          end else begin
            r_state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          r_dmem_we <= mem_write;
          r_state   <= (mem_read || mem_write) ? ST_MEM : ST_WRITEBACK;
        end
        ST_MEM: begin
          if (dmem_ack) begin
            r_state <= ST_WRITEBACK;
          end else if (w_expired) begin
            r_state <= ST_TRAP;
            r_cause <= CAUSE_DMEM_TO;
          end
        end
        ST_WRITEBACK: begin
          r_retired <= r_retired + CNT_W'(1);
          r_state   <= run ? ST_FETCH : ST_IDLE;
        end
        ST_TRAP: begin
          r_state <= ST_TRAP;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req   = (r_state == ST_FETCH);
  assign ir_load    = imem_req && imem_ack;
  assign dmem_req   = (r_state == ST_MEM);
  assign dmem_we    = dmem_req && r_dmem_we;
  assign pc_we      = (r_state == ST_WRITEBACK);
  assign rf_we      = pc_we && reg_write;
  assign trap       = (r_state == ST_TRAP);
  assign trap_cause = r_cause;
  assign retired    = r_retired;
  assign state_o    = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed scoreboard bench for instr_sequencer (TIMEOUT=4, CNT_W=4)
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, imem_ack, valid_inst, mem_read, mem_write, reg_write, dmem_ack;
  logic       imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we, trap;
  logic [3:0] retired;
  logic [1:0] trap_cause;
  logic [2:0] state_o;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] exp_ret;

  typedef struct packed {
    logic [2:0] st;
    logic       im;
    logic       ir;
    logic       dr;
    logic       dw;
    logic       rf;
    logic       pc;
    logic       tr;
    logic [1:0] ca;
    logic [3:0] rt;
  } exp_t;

  exp_t sb[$];

  instr_sequencer #(.TIMEOUT(4), .CNT_W(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .ir_load    (ir_load),
    .valid_inst (valid_inst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .rf_we      (rf_we),
    .pc_we      (pc_we),
    .retired    (retired),
    .trap       (trap),
    .trap_cause (trap_cause),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // in = {run, imem_ack, valid_inst, mem_read, mem_write, reg_write, dmem_ack}
  task automatic step(input string tag, input logic [6:0] in, input logic [2:0] es,
                      input logic ew, input logic [1:0] ec);
    exp_t e;
    exp_t got;
    {run, imem_ack, valid_inst, mem_read, mem_write, reg_write, dmem_ack} = in;
    e.st = es;
    e.im = (es == 3'd1);
    e.ir = (es == 3'd1) && in[5];
    e.dr = (es == 3'd4);
    e.dw = (es == 3'd4) && ew;
    e.rf = (es == 3'd5) && in[1];
    e.pc = (es == 3'd5);
    e.tr = (es == 3'd6);
    e.ca = ec;
    e.rt = exp_ret;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    check({tag, ".state"},      32'(state_o),    32'(got.st));
    check({tag, ".imem_req"},   32'(imem_req),   32'(got.im));
    check({tag, ".ir_load"},    32'(ir_load),    32'(got.ir));
    check({tag, ".dmem_req"},   32'(dmem_req),   32'(got.dr));
    check({tag, ".dmem_we"},    32'(dmem_we),    32'(got.dw));
    check({tag, ".rf_we"},      32'(rf_we),      32'(got.rf));
    check({tag, ".pc_we"},      32'(pc_we),      32'(got.pc));
    check({tag, ".trap"},       32'(trap),       32'(got.tr));
    check({tag, ".trap_cause"}, 32'(trap_cause), 32'(got.ca));
    check({tag, ".retired"},    32'(retired),    32'(got.rt));
    if (es == 3'd5) exp_ret = exp_ret + 4'd1;
    @(negedge clk);
  endtask

  task automatic alu(input string tag, input logic run_dec, input logic run_wb);
    step({tag, ".F"},  7'b1110010, 3'd1, 1'b0, 2'b00);
    step({tag, ".D"},  {run_dec, 6'b010010}, 3'd2, 1'b0, 2'b00);
    step({tag, ".E"},  {run_dec, 6'b010010}, 3'd3, 1'b0, 2'b00);
    step({tag, ".WB"}, {run_wb, 6'b010010},  3'd5, 1'b0, 2'b00);
  endtask

  task automatic mem_instr(input string tag, input logic mr, input logic mw, input logic rw,
                           input int waits);
    step({tag, ".F"}, {3'b111, mr, mw, rw, 1'b0}, 3'd1, 1'b0, 2'b00);
    step({tag, ".D"}, {3'b101, mr, mw, rw, 1'b0}, 3'd2, 1'b0, 2'b00);
    step({tag, ".E"}, {3'b101, mr, mw, rw, 1'b0}, 3'd3, 1'b0, 2'b00);
    for (int i = 0; i < waits; i++)
      step({tag, ".Mw"}, {3'b101, mr, mw, rw, 1'b0}, 3'd4, mw, 2'b00);
    step({tag, ".Mack"}, {3'b101, mr, mw, rw, 1'b1}, 3'd4, mw, 2'b00);
    step({tag, ".WB"},   {3'b101, mr, mw, rw, 1'b0}, 3'd5, 1'b0, 2'b00);
  endtask

  task automatic do_reset(input string tag);
    rst_n   = 1'b0;
    exp_ret = 4'd0;
    step(tag, 7'b0000000, 3'd0, 1'b0, 2'b00);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    {run, imem_ack, valid_inst, mem_read, mem_write, reg_write, dmem_ack} = 7'b0;
    exp_ret = 4'd0;
    @(negedge clk);
    step("reset", 7'b0000000, 3'd0, 1'b0, 2'b00);
    rst_n = 1'b1;

    // acks with no request pending and run low leave the FSM idle
    step("idle_ack", 7'b0100001, 3'd0, 1'b0, 2'b00);
    step("idle_go",  7'b1000000, 3'd0, 1'b0, 2'b00);

    repeat (3) alu("alur", 1'b1, 1'b1);
    mem_instr("load",  1'b1, 1'b0, 1'b1, 3);
    mem_instr("store", 1'b0, 1'b1, 1'b0, 1);

    // fetch ack on the last allowed wait cycle
    repeat (3) step("fetch_wait", 7'b1010010, 3'd1, 1'b0, 2'b00);
    alu("fetch_edge", 1'b1, 1'b1);

    // retired counter wraps through zero
    repeat (10) alu("wrap", 1'b1, 1'b1);

    // run dropped during DECODE: finish, then park
    alu("drop", 1'b0, 1'b0);
    repeat (3) step("park", 7'b0010010, 3'd0, 1'b0, 2'b00);

    // asynchronous reset mid data-memory handshake
    step("mr.I", 7'b1000000, 3'd0, 1'b0, 2'b00);
    step("mr.F", 7'b1111000, 3'd1, 1'b0, 2'b00);
    step("mr.D", 7'b1011000, 3'd2, 1'b0, 2'b00);
    step("mr.E", 7'b1011000, 3'd3, 1'b0, 2'b00);
    {run, imem_ack, valid_inst, mem_read, mem_write, reg_write, dmem_ack} = 7'b1011000;
    #1;
    check("mr.pre_dmem_req", 32'(dmem_req), 32'd1);
    check("mr.pre_retired",  32'(retired),  32'(exp_ret));
    rst_n = 1'b0;
    #1;
    check("mr.dmem_req", 32'(dmem_req), 32'd0);
    check("mr.trap",     32'(trap),     32'd0);
    check("mr.retired",  32'(retired),  32'd0);
    check("mr.state",    32'(state_o),  32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_ret = 4'd0;

    // illegal instruction trap holds for 100 cycles regardless of inputs
    step("ill.I", 7'b1000000, 3'd0, 1'b0, 2'b00);
    step("ill.F", 7'b1110000, 3'd1, 1'b0, 2'b00);
    step("ill.D", 7'b1000000, 3'd2, 1'b0, 2'b00);
    for (int i = 0; i < 100; i++)
      step("ill.hold", 7'($urandom), 3'd6, 1'b0, 2'b01);
    do_reset("ill.rst");

    // imem timeout
    step("ito.I", 7'b1000000, 3'd0, 1'b0, 2'b00);
    repeat (4) step("ito.F", 7'b1010000, 3'd1, 1'b0, 2'b00);
    repeat (3) step("ito.trap", 7'b1111111, 3'd6, 1'b0, 2'b10);
    do_reset("ito.rst");

    // dmem timeout
    step("dto.I", 7'b1000000, 3'd0, 1'b0, 2'b00);
    step("dto.F", 7'b1111000, 3'd1, 1'b0, 2'b00);
    step("dto.D", 7'b1011000, 3'd2, 1'b0, 2'b00);
    step("dto.E", 7'b1011000, 3'd3, 1'b0, 2'b00);
    repeat (4) step("dto.M", 7'b1011000, 3'd4, 1'b0, 2'b00);
    repeat (3) step("dto.trap", 7'b1111111, 3'd6, 1'b0, 2'b11);
    do_reset("dto.rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
